operand_demux_1x2_4bit: RTL and testbench

Receive-side operand steering block for the UART adder. It takes the byte stream from the UART receiver, decodes ASCII hex digits, and routes alternate digits to the two 4-bit adder operand outputs. This is the inverse of the 2:1 operand selection, one input stream steered to two destinations. It presents each completed operand pair under a valid/ready handshake and flags malformed or dropped input.

---
 rtl/operand_demux_1x2_4bit_if.sv | 21 ++
 rtl/operand_demux_1x2_4bit.sv | 72 +++++++
 tb/tb_operand_demux_1x2_4bit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/operand_demux_1x2_4bit_if.sv
// operand_demux_1x2_4bit_if: byte stream in, operand pair out with valid/ready, error/overrun pulses
//   master: UART receiver / consumer side (drives rx_data_i, rx_valid_i, out_ready_i)
//   slave:  the demux (drives a_o, b_o, out_valid_o, error_o, overrun_o)
interface operand_demux_1x2_4bit_if;
   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic [3:0] a_o;
   logic [3:0] b_o;
   logic       out_valid_o;
   logic       out_ready_i;
   logic       error_o;
   logic       overrun_o;
   modport master (
      output rx_data_i, rx_valid_i, out_ready_i,
      input  a_o, b_o, out_valid_o, error_o, overrun_o
   );
   modport slave (
      input  rx_data_i, rx_valid_i, out_ready_i,
      output a_o, b_o, out_valid_o, error_o, overrun_o
   );
endinterface

// File: rtl/operand_demux_1x2_4bit.sv
// operand_demux_1x2_4bit: decode ASCII hex digits, steer alternate digits to operands A/B
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : rx_data_i/rx_valid_i byte strobe in; a_o/b_o/out_valid_o/out_ready_i pair out;
//                  error_o (invalid byte), overrun_o (digit dropped while pair pending)
module operand_demux_1x2_4bit #(
   parameter bit IGNORE_CRLF = 1'b1
) (
   input logic                     clk_i,
   input logic                     rst_i,
   operand_demux_1x2_4bit_if.slave bus
);
   typedef enum logic [1:0] {WAIT_A, WAIT_B, HOLD} state_t;
   state_t     state, state_n;
   logic [7:0] d;
   logic [3:0] a_stage, a_stage_n, a_q, a_n, b_q, b_n, nib;
   logic       err_q, err_n, ovr_q, ovr_n, is_hex, skip, dig, bad, hs;
   assign d = bus.rx_data_i;
   always_comb begin
      is_hex = (d >= 8'h30 && d <= 8'h39) || (d >= 8'h41 && d <= 8'h46) || (d >= 8'h61 && d <= 8'h66);
      // letters have bit 6 set; low nibble 1..6 maps to 10..15
      nib = d[6] ? d[3:0] + 4'd9 : d[3:0];
      skip = IGNORE_CRLF && (d == 8'h0D || d == 8'h0A);
      dig = bus.rx_valid_i && !skip && is_hex;
      bad = bus.rx_valid_i && !skip && !is_hex;
      hs = (state == HOLD) && bus.out_ready_i;
      state_n = state;
      a_stage_n = a_stage;
      a_n = a_q;
      b_n = b_q;
      err_n = bad;
      ovr_n = 1'b0;
      case (state)
         WAIT_A: if (dig) begin
            a_stage_n = nib;
            state_n = WAIT_B;
         end
         WAIT_B: if (dig) begin
            a_n = a_stage;
            b_n = nib;
            state_n = HOLD;
         end else if (bad) state_n = WAIT_A;
         HOLD: if (hs) begin
            // a digit arriving with the handshake starts the next pair immediately
            a_stage_n = dig ? nib : a_stage;
            state_n = dig ? WAIT_B : WAIT_A;
         end else ovr_n = dig;
         default: state_n = WAIT_A;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= WAIT_A;
         a_stage <= '0;
         a_q <= '0;
         b_q <= '0;
         err_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         state <= state_n;
         a_stage <= a_stage_n;
         a_q <= a_n;
         b_q <= b_n;
         err_q <= err_n;
         ovr_q <= ovr_n;
      end
   end
   assign bus.a_o = a_q;
   assign bus.b_o = b_q;
   assign bus.out_valid_o = (state == HOLD);
   assign bus.error_o = err_q;
   assign bus.overrun_o = ovr_q;
endmodule

// File: tb/tb_operand_demux_1x2_4bit.sv
// tb_operand_demux_1x2_4bit: checks both IGNORE_CRLF settings against a behavioural model
module tb_operand_demux_1x2_4bit;
   logic       clk = 1'b0, rst = 1'b0, rx_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   int         checks = 0, errors = 0;
   bit         started = 1'b0;
   operand_demux_1x2_4bit_if bus0 ();
   operand_demux_1x2_4bit_if bus1 ();
   assign bus0.rx_data_i = rx_data;
   assign bus0.rx_valid_i = rx_valid;
   assign bus0.out_ready_i = out_ready;
   assign bus1.rx_data_i = rx_data;
   assign bus1.rx_valid_i = rx_valid;
   assign bus1.out_ready_i = out_ready;
   operand_demux_1x2_4bit #(.IGNORE_CRLF(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
   operand_demux_1x2_4bit #(.IGNORE_CRLF(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
   always #5 clk = ~clk;
   // {a, b, valid, error, overrun}
   logic [10:0] act [2];
   assign act[0] = {bus0.a_o, bus0.b_o, bus0.out_valid_o, bus0.error_o, bus0.overrun_o};
   assign act[1] = {bus1.a_o, bus1.b_o, bus1.out_valid_o, bus1.error_o, bus1.overrun_o};
   // model: staged digit (-1 = none), whether a pair is presented, last pair, pulses
   int         m_stage [2];
   bit         m_full [2], m_err [2], m_ovr [2];
   logic [3:0] m_a [2], m_b [2];
   function automatic int hexval(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      return -1;
   endfunction
   function automatic logic [10:0] model_vec(input int k);
      return {m_a[k], m_b[k], m_full[k], m_err[k], m_ovr[k]};
   endfunction
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int h;
         bit skip;
         h = hexval(rx_data);
         skip = (k == 0) && (rx_data == 8'h0D || rx_data == 8'h0A);
         m_err[k] = 1'b0;
         m_ovr[k] = 1'b0;
         if (rst) begin
            m_stage[k] = -1;
            m_full[k] = 1'b0;
            m_a[k] = 4'h0;
            m_b[k] = 4'h0;
         end else begin
            if (m_full[k] && out_ready) m_full[k] = 1'b0;
            if (rx_valid && !skip) begin
               if (h < 0) begin
                  m_err[k] = 1'b1;
                  if (!m_full[k]) m_stage[k] = -1;
               end else if (m_full[k]) m_ovr[k] = 1'b1;
               else if (m_stage[k] < 0) m_stage[k] = h;
               else begin
                  m_a[k] = 4'(m_stage[k]);
                  m_b[k] = 4'(h);
                  m_full[k] = 1'b1;
                  m_stage[k] = -1;
               end
            end
         end
      end
      started = 1'b1;
   end
   always @(negedge clk) if (started) begin
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (act[k] !== model_vec(k)) begin
            errors++;
            $display("FAIL model_cmp inst%0d t=%0t got a/b/v/e/o=%h/%h/%b/%b/%b want %h/%h/%b/%b/%b", k, $time,
                     act[k][10:7], act[k][6:3], act[k][2], act[k][1], act[k][0],
                     m_a[k], m_b[k], m_full[k], m_err[k], m_ovr[k]);
         end
      end
   end
   task automatic tick(input logic v, input logic [7:0] dat, input logic r, input logic rs);
      rx_valid = v;
      rx_data = dat;
      out_ready = r;
      rst = rs;
      @(posedge clk);
      #1;
   endtask
   task automatic pin(input int k, input logic [10:0] want, input string nm);
      checks++;
      if (act[k] !== want) begin
         errors++;
         $display("FAIL %s inst%0d got %h want %h", nm, k, act[k], want);
      end
   endtask
   initial begin
      string s;
      s = "0123456789abcdef";
      tick(0, 8'h00, 0, 1);
      pin(0, 11'h000, "reset");
      pin(1, 11'h000, "reset");
      tick(1, "3", 0, 0);
      tick(1, "a", 0, 0);
      pin(0, {4'h3, 4'hA, 3'b100}, "pair_3a");
      tick(0, 8'h00, 1, 0);
      pin(0, {4'h3, 4'hA, 3'b000}, "handshake_3a");
      tick(1, "F", 0, 0);
      tick(1, "G", 0, 0);
      pin(0, {4'h3, 4'hA, 3'b010}, "error_G");
      tick(1, "1", 0, 0);
      tick(1, "2", 0, 0);
      pin(0, {4'h1, 4'h2, 3'b100}, "pair_12");
      tick(0, 8'h00, 1, 0);
      tick(1, "5", 0, 0);
      tick(1, 8'h0D, 0, 0);
      pin(0, {4'h1, 4'h2, 3'b000}, "cr_ignored");
      pin(1, {4'h1, 4'h2, 3'b010}, "cr_error");
      tick(1, 8'h0A, 0, 0);
      pin(1, {4'h1, 4'h2, 3'b010}, "lf_error");
      tick(1, "9", 0, 0);
      pin(0, {4'h5, 4'h9, 3'b100}, "pair_59");
      pin(1, {4'h1, 4'h2, 3'b000}, "nine_staged");
      tick(0, 8'h00, 0, 1);
      tick(1, "7", 0, 0);
      tick(1, "8", 0, 0);
      pin(0, {4'h7, 4'h8, 3'b100}, "pair_78");
      tick(1, "4", 0, 0);
      pin(0, {4'h7, 4'h8, 3'b101}, "overrun_4");
      tick(1, "2", 1, 0);
      pin(0, {4'h7, 4'h8, 3'b000}, "hs_capture_2");
      tick(1, "6", 0, 0);
      pin(0, {4'h2, 4'h6, 3'b100}, "pair_26");
      tick(0, 8'h00, 1, 0);
      tick(1, "C", 0, 0);
      tick(0, 8'h00, 0, 1);
      pin(0, 11'h000, "mid_reset");
      tick(1, "D", 0, 0);
      tick(1, "E", 0, 0);
      pin(0, {4'hD, 4'hE, 3'b100}, "pair_de");
      for (int i = 0; i < 16; i++) begin
         tick(1, s[i], 1, 0);
         if (i % 2 == 1) pin(0, {4'(i - 1), 4'(i), 3'b100}, "stream_pair");
         else pin(0, {act[0][10:3], 3'b000}, "stream_gap");
      end
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] c;
         case ($urandom_range(0, 3))
            0: c = 8'($urandom);
            1: c = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            default: c = s[$urandom_range(0, 15)];
         endcase
         if ($urandom_range(0, 1) != 0 && c >= "a" && c <= "f") c = c - 8'h20;
         tick(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
